fetch_stage: RTL

Instruction-fetch stage for the pipelined WISC CPU. It owns the PC, issues requests to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register consumed by decode. It handles stalls from hazard detection, redirects from branch resolution in ID, and HLT detection, and it tolerates multi-cycle memory such as a future I-cache.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_stage_if.sv | 13 +
 rtl/fetch_skid_buf.sv | 33 +++
 rtl/fetch_stage.sv | 135 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants used by the fetch stage
package cpu_pkg;

    localparam int          WORD_W           = 16;
    localparam logic [3:0]  OPC_HLT          = 4'hF;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DROP,
        ST_HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic is_hlt(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: 4] == OPC_HLT;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory req/ack handshake between fetch and memory
interface fetch_stage_if;
    import cpu_pkg::*;

    logic              req;
    logic [WORD_W-1:0] addr;
    logic              ack;
    logic [WORD_W-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - single-entry {instr, pc} holding buffer used while decode stalls
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         valid,
    output logic         full,
    output fetch_entry_t dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

    // One entry: holding anything means no room for more.
    assign full = valid;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, imem request FSM and IF/ID register; FETCH_PERF_EN adds perf counters
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_stage_if.master     imem,
    input  logic              stall_if,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    output logic              ifid_valid,
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] ifid_pc,
    output logic [WORD_W-1:0] ifid_pc_plus2,
    output logic [WORD_W-1:0] pc,
    output logic              hlt
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_bubbles
`endif
);

    fetch_state_t      state;
    logic [WORD_W-1:0] drop_addr;
    logic              req_int;
    logic              accept;
    logic              ifid_load;
    logic              hlt_retire;
    logic              skid_valid;
    logic              skid_full;
    logic              skid_push;
    logic              skid_pop;
    fetch_entry_t      skid_in;
    fetch_entry_t      skid_q;

    // Gated by rst_n so the request is low for the whole reset and high right after release.
    assign req_int   = rst_n && (((state == ST_RUN) && !skid_full) || (state == ST_DROP));
    assign imem.req  = req_int;
    assign imem.addr = (state == ST_DROP) ? drop_addr : pc;

    assign accept     = (state == ST_RUN) && req_int && imem.ack && !branch_taken;
    assign ifid_load  = !ifid_valid || !stall_if;
    assign skid_push  = accept && !ifid_load;
    assign skid_pop   = !branch_taken && ifid_load && skid_valid;
    assign skid_in    = {imem.rdata, pc};
    assign hlt_retire = ifid_valid && is_hlt(ifid_instr) && !stall_if && !branch_taken;

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (skid_push),
        .pop   (skid_pop),
        .flush (branch_taken),
        .din   (skid_in),
        .valid (skid_valid),
        .full  (skid_full),
        .dout  (skid_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RUN;
            pc            <= RESET_PC;
            drop_addr     <= '0;
            ifid_valid    <= 1'b0;
            ifid_instr    <= '0;
            ifid_pc       <= '0;
            ifid_pc_plus2 <= '0;
            hlt           <= 1'b0;
        end else begin
            if (hlt_retire)
                hlt <= 1'b1;
            if (branch_taken) begin
                ifid_valid <= 1'b0;
                pc         <= branch_target;
                // An unacked request cannot be withdrawn; remember its address and eat its data.
                if (req_int && !imem.ack) begin
                    state <= ST_DROP;
                    if (state == ST_RUN)
                        drop_addr <= pc;
                end else begin
                    state <= ST_RUN;
                end
            end else begin
                if (ifid_load) begin
                    if (skid_valid) begin
                        ifid_valid    <= 1'b1;
                        ifid_instr    <= skid_q.instr;
                        ifid_pc       <= skid_q.pc;
                        ifid_pc_plus2 <= skid_q.pc + 16'd2;
                    end else if (accept) begin
                        ifid_valid    <= 1'b1;
                        ifid_instr    <= imem.rdata;
                        ifid_pc       <= pc;
                        ifid_pc_plus2 <= pc + 16'd2;
                    end else begin
                        ifid_valid    <= 1'b0;
                    end
                end
                case (state)
                    ST_RUN: begin
                        if (accept) begin
                            pc <= pc + 16'd2;
                            if (is_hlt(imem.rdata))
                                state <= ST_HALTED;
                        end
                    end
                    ST_DROP: begin
                        if (imem.ack)
                            state <= ST_RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (accept && (perf_fetched != 16'hFFFF))
                perf_fetched <= perf_fetched + 16'd1;
            if (!ifid_valid && (state != ST_HALTED) && (perf_bubbles != 16'hFFFF))
                perf_bubbles <= perf_bubbles + 16'd1;
        end
    end
`endif

endmodule
